// File: rtl/norm_pkg.sv
// Shared constants and helpers for the norm_shift normalizing shifter:
// ceil-log2 and the split of the leading-one descriptor into found bit and index.
package norm_pkg;

    function automatic int cLog2(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // The descriptor is passed zero-extended to 32 bits; cw is the index width.
    function automatic logic lo_found(input logic [31:0] lo, input int cw);
        return lo[cw];
    endfunction

    function automatic logic [31:0] lo_index(input logic [31:0] lo, input int cw);
        return lo & ((32'd1 << cw) - 32'd1);
    endfunction

endpackage

// File: rtl/norm_shift_barrel_shl.sv
// Combinational logarithmic left shifter used by norm_shift: one mux stage
// per shift-amount bit.
module barrel_shl
    import norm_pkg::*;
#(
    parameter  int xWL = 32,
    localparam int SW  = cLog2(xWL)
) (
    input  logic [xWL-1:0] i_x,
    input  logic [SW-1:0]  i_shamt,
    output logic [xWL-1:0] o_y
);

    logic [xWL-1:0] w_stage [0:SW];

    assign w_stage[0] = i_x;

    for (genvar g = 0; g < SW; g++) begin : g_stage
        assign w_stage[g+1] = i_shamt[g] ? (w_stage[g] << (2**g)) : w_stage[g];
    end

    assign o_y = w_stage[SW];

endmodule

// File: rtl/norm_shift.sv
// Two-stage valid/ready normalizing shifter: moves the leading one of x to the MSB.
// Optional saturating zero-result counter enabled by defining NORM_SHIFT_ZCOUNT_EN.
module norm_shift
    import norm_pkg::*;
#(
    parameter  int xWL      = 32,
    localparam int ctrWidth = cLog2(xWL)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                sclr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [xWL-1:0]      x,
    input  logic [ctrWidth:0]   lo,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [xWL-1:0]      y,
    output logic [ctrWidth-1:0] shamt,
    output logic                zero
`ifdef NORM_SHIFT_ZCOUNT_EN
    ,
    output logic [15:0]         zcount
`endif
);

    localparam logic [ctrWidth-1:0] MAX_IDX = ctrWidth'(xWL - 1);

    logic [31:0]         w_lo_ext;
    logic                w_found;
    logic [ctrWidth-1:0] w_idx;
    logic [ctrWidth-1:0] w_s1_shamt_d;
    logic [xWL-1:0]      w_y;
    logic                w_s2_adv;
    logic                w_s1_adv;

    logic                r_s1_valid;
    logic [xWL-1:0]      r_s1_x;
    logic [ctrWidth-1:0] r_s1_shamt;
    logic                r_s1_zero;
    logic                r_out_valid;
    logic [xWL-1:0]      r_y;
    logic [ctrWidth-1:0] r_shamt;
    logic                r_zero;

    assign w_lo_ext     = 32'(lo);
    assign w_found      = lo_found(w_lo_ext, ctrWidth);
    assign w_idx        = ctrWidth'(lo_index(w_lo_ext, ctrWidth));
    // lo is trusted as-is; a missing leading one forces a zero result.
    assign w_s1_shamt_d = w_found ? (MAX_IDX - w_idx) : {ctrWidth{1'b0}};

    assign w_s2_adv = ~r_out_valid | out_ready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign in_ready = w_s1_adv;

    barrel_shl #(.xWL(xWL)) u_shl (
        .i_x     (r_s1_x),
        .i_shamt (r_s1_shamt),
        .o_y     (w_y)
    );

    // Stage 1: capture the operand and its shift amount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_x     <= {xWL{1'b0}};
            r_s1_shamt <= {ctrWidth{1'b0}};
            r_s1_zero  <= 1'b0;
        end else if (ce) begin
            if (sclr) begin
                r_s1_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_x     <= w_found ? x : {xWL{1'b0}};
                    r_s1_shamt <= w_s1_shamt_d;
                    r_s1_zero  <= ~w_found;
                end
            end
        end
    end

    // Stage 2: register the shifted result; data only changes on a fresh load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= {xWL{1'b0}};
            r_shamt     <= {ctrWidth{1'b0}};
            r_zero      <= 1'b0;
        end else if (ce) begin
            if (sclr) begin
                r_out_valid <= 1'b0;
            end else if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_y     <= w_y;
                    r_shamt <= r_s1_shamt;
                    r_zero  <= r_s1_zero;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign shamt     = r_shamt;
    assign zero      = r_zero;

`ifdef NORM_SHIFT_ZCOUNT_EN
    logic [15:0] r_zcount;

    // Saturating count of delivered zero results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zcount <= 16'd0;
        end else if (ce) begin
            if (sclr) begin
                r_zcount <= 16'd0;
            end else if (r_out_valid & out_ready & r_zero & (r_zcount != 16'hFFFF)) begin
                r_zcount <= r_zcount + 16'd1;
            end
        end
    end

    assign zcount = r_zcount;
`endif

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift: queue-based reference model plus directed
// scenarios and a randomized handshake/ce/sclr run.
module tb_norm_shift;

    logic        clk = 1'b0;
    logic        rst, ce, sclr, in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] x, y;
    logic [5:0]  lo;
    logic [4:0]  shamt;
`ifdef NORM_SHIFT_ZCOUNT_EN
    logic [15:0] zcount;
`endif

    norm_shift #(.xWL(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .sclr      (sclr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .lo        (lo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .shamt     (shamt),
        .zero      (zero)
`ifdef NORM_SHIFT_ZCOUNT_EN
        ,
        .zcount    (zcount)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    // Operands in flight, oldest first, with ce-edges elapsed since acceptance.
    logic [31:0] q_y[$];
    logic [4:0]  q_sh[$];
    logic        q_z[$];
    int          q_age[$];
    logic [4:0]  obs_sh[$];
    int          zc_model = 0;
    int          tries;

    logic        s_iv, s_or, s_ce, s_sclr, s_ov_exp, s_ir_exp;
    logic [31:0] s_x;
    logic [5:0]  s_lo;
    logic [4:0]  s_shamt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        q_y.delete();
        q_sh.delete();
        q_z.delete();
        q_age.delete();
    endtask

    // Compare DUT against the model, then sample the pre-edge inputs.
    task automatic compare();
        logic ov, ir;
        ov = (q_y.size() > 0) && (q_age[0] >= 1);
        ir = (q_y.size() < 2) || out_ready;
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("in_ready", 32'(in_ready), 32'(ir));
        if (ov) begin
            chk("y", y, q_y[0]);
            chk("shamt", 32'(shamt), 32'(q_sh[0]));
            chk("zero", 32'(zero), 32'(q_z[0]));
        end
`ifdef NORM_SHIFT_ZCOUNT_EN
        chk("zcount", 32'(zcount), 32'(zc_model));
`endif
        s_iv = in_valid; s_or = out_ready; s_ce = ce; s_sclr = sclr;
        s_x = x; s_lo = lo; s_shamt = shamt; s_ov_exp = ov; s_ir_exp = ir;
    endtask

    task automatic model_update();
        logic [4:0] sh;
        if (!s_ce) return;
        if (s_sclr) begin
            clear_model();
            zc_model = 0;
            return;
        end
        foreach (q_age[i]) q_age[i]++;
        if (s_ov_exp && s_or) begin
            obs_sh.push_back(s_shamt);
            if (q_z[0] && zc_model < 65535) zc_model++;
            void'(q_y.pop_front());
            void'(q_sh.pop_front());
            void'(q_z.pop_front());
            void'(q_age.pop_front());
        end
        if (s_iv && s_ir_exp) begin
            if (s_lo[5]) begin
                sh = 5'd31 - s_lo[4:0];
                q_y.push_back(s_x << sh);
                q_sh.push_back(sh);
                q_z.push_back(1'b0);
            end else begin
                q_y.push_back(32'd0);
                q_sh.push_back(5'd0);
                q_z.push_back(1'b1);
            end
            q_age.push_back(0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic push_op(input logic [31:0] xv, input logic [5:0] lov, output int n);
        logic acc;
        x = xv; lo = lov; in_valid = 1'b1; n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            #1;
            acc = in_ready & ce & ~sclr;
            tick();
            n++;
        end
        if (!acc) begin
            n_checks++; n_errs++;
            $display("FAIL push_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic gen_op();
        int m, idx;
        logic [31:0] xv;
        m  = $urandom_range(0, 9);
        xv = $urandom >> $urandom_range(0, 31);
        if (m < 7) begin
            if (xv == 32'd0) xv = 32'd1;
            idx = 0;
            for (int b = 0; b < 32; b++) if (xv[b]) idx = b;
            lo = {1'b1, 5'(idx)};
        end else if (m == 7) begin
            xv = 32'd0;
            lo = {1'b0, 5'($urandom_range(0, 31))};
        end else if (m == 8) begin
            lo = {1'b0, 5'($urandom_range(0, 31))};
        end else begin
            lo = {1'b1, 5'($urandom_range(0, 31))};
        end
        x = xv;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = 32'd0; lo = 6'd0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_y", y, 32'd0);
        chk("rst_shamt", 32'(shamt), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // x=1 with leading one at bit 0
        out_ready = 1'b1;
        push_op(32'h0000_0001, {1'b1, 5'd0}, tries);
        chk("first_edge_accept", 32'(tries), 32'd1);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_y", y, 32'h8000_0000);
        chk("lat_shamt", 32'(shamt), 32'd31);
        chk("lat_zero", 32'(zero), 32'd0);
        tick();

        // No leading one
        push_op(32'h0000_0000, {1'b0, 5'd7}, tries);
        tick();
        chk("zr_y", y, 32'd0);
        chk("zr_shamt", 32'(shamt), 32'd0);
        chk("zr_zero", 32'(zero), 32'd1);
`ifdef NORM_SHIFT_ZCOUNT_EN
        chk("zcount_before", 32'(zcount), 32'd0);
`endif
        tick();
`ifdef NORM_SHIFT_ZCOUNT_EN
        chk("zcount_after", 32'(zcount), 32'd1);
`endif

        // Leading one already at the MSB
        push_op(32'hDEAD_BEEF, {1'b1, 5'd31}, tries);
        tick();
        chk("msb_y", y, 32'hDEAD_BEEF);
        chk("msb_shamt", 32'(shamt), 32'd0);
        tick();

        // Backpressure: 4 operands, 5 stalled cycles
        obs_sh.delete();
        out_ready = 1'b0;
        push_op(32'd1, {1'b1, 5'd0}, tries);
        push_op(32'd2, {1'b1, 5'd1}, tries);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (3) begin
            tick();
            chk("bp_hold_y", y, 32'h8000_0000);
            chk("bp_hold_shamt", 32'(shamt), 32'd31);
        end
        out_ready = 1'b1;
        push_op(32'd4, {1'b1, 5'd2}, tries);
        push_op(32'd8, {1'b1, 5'd3}, tries);
        repeat (4) tick();
        chk("bp_count", 32'(obs_sh.size()), 32'd4);
        if (obs_sh.size() == 4) begin
            chk("bp_order0", 32'(obs_sh[0]), 32'd31);
            chk("bp_order1", 32'(obs_sh[1]), 32'd30);
            chk("bp_order2", 32'(obs_sh[2]), 32'd29);
            chk("bp_order3", 32'(obs_sh[3]), 32'd28);
        end

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        push_op(32'd3, {1'b1, 5'd1}, tries);
        push_op(32'd5, {1'b1, 5'd2}, tries);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_y", y, 32'd0);
        chk("arst_shamt", 32'(shamt), 32'd0);
        chk("arst_zero", 32'(zero), 32'd0);
        clear_model();
        zc_model = 0;
        rst = 1'b0;
        out_ready = 1'b1;
        push_op(32'd16, {1'b1, 5'd4}, tries);
        chk("arst_first_edge", 32'(tries), 32'd1);
        chk("arst_empty", 32'(out_valid), 32'd0);
        tick();
        chk("arst_alone_valid", 32'(out_valid), 32'd1);
        chk("arst_alone_shamt", 32'(shamt), 32'd27);
        tick();
        chk("arst_alone_only", 32'(out_valid), 32'd0);

        // Synchronous clear on an accepting edge
        in_valid = 1'b1; x = 32'd7; lo = {1'b1, 5'd2}; sclr = 1'b1;
        tick();
        sclr = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            tick();
            chk("sclr_no_output", 32'(out_valid), 32'd0);
        end

        // Clock enable low while a result waits
        out_ready = 1'b0;
        push_op(32'h0000_0100, {1'b1, 5'd8}, tries);
        tick();
        chk("ce_valid", 32'(out_valid), 32'd1);
        ce = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("ce_hold_valid", 32'(out_valid), 32'd1);
            chk("ce_hold_shamt", 32'(shamt), 32'd23);
            chk("ce_hold_y", y, 32'h8000_0000);
        end
        ce = 1'b1;
        tick();
        chk("ce_resume_xfer", 32'(out_valid), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            ce        = ($urandom_range(0, 7) != 0);
            sclr      = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            gen_op();
            tick();
        end
        ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("drained", 32'(q_y.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/norm_shift.md
NORM_SHIFT -- requirements
Module: norm_shift

Interface
REQ-001 SHALL have parameter xWL, default 32, meaning operand word length in bits.
REQ-002 SHALL have local constant ctrWidth = ceil(log2(xWL)), meaning the index width; not overridable.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port ce, input, 1 bit: clock enable; when low, all state holds.
REQ-006 SHALL have port sclr, input, 1 bit: synchronous clear of pipeline valids, qualified by ce.
REQ-007 SHALL have port in_valid, input, 1 bit: the upstream operand is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-009 SHALL have port x, input, xWL bits: the operand to normalize.
REQ-010 SHALL have port lo, input, ctrWidth+1 bits: leading-one descriptor, where MSB = found and the low bits = index of the leading one.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port y, output, xWL bits: x shifted left so that the leading one sits at bit xWL-1.
REQ-014 SHALL have port shamt, output, ctrWidth bits: left-shift amount applied.
REQ-015 SHALL have port zero, output, 1 bit: the operand had no leading one.

Function
REQ-016 SHALL transfer an input when in_valid & in_ready & ce are all high at a rising edge.
REQ-017 SHALL transfer an output when out_valid & out_ready & ce are all high at a rising edge.
REQ-018 SHALL be a 2-stage pipeline:
- S1 registers x and computes shamt = (xWL-1) - lo index.
- S2 registers y = x << shamt, shamt and zero.
REQ-019 SHALL present the result on out_valid two ce-qualified cycles after acceptance when there is no backpressure.
REQ-020 SHALL advance S2 when ~out_valid | out_ready.
REQ-021 SHALL advance S1 when ~S1_valid | (S2 advances).
REQ-022 SHALL drive in_ready = ~S1_valid | (S2 advances), combinationally, with no dependency on in_valid.
REQ-023 SHALL sustain full throughput of one operand per cycle while out_ready stays high.
REQ-024 SHALL hold y, shamt and zero stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, when lo found=0, produce zero=1, y=0 and shamt=0, regardless of x.
REQ-026 SHALL, when lo index = xWL-1, produce shamt=0 and y=x.
REQ-027 SHALL trust lo without checking it against x; results for an inconsistent lo are the plain shift of x by the computed shamt.
REQ-028 SHALL preserve operand order; no operand is dropped or duplicated under any stall pattern.
REQ-029 SHALL, when ce=0, keep every register unchanged and keep in_ready and out_valid at their held-state values.
REQ-030 SHALL, on sclr=1 with ce=1, clear both stage valids at the edge; any transfer on that edge is discarded.

Reset
REQ-031 SHALL, on rst=1, immediately force S1_valid=0, out_valid=0, y=0, shamt=0 and zero=0, regardless of clk or ce.
REQ-032 SHALL, during reset, drive in_ready=1 (pipeline empty).
REQ-033 SHALL, when rst is asserted mid-operation, lose in-flight operands without producing a partial output.
REQ-034 SHALL accept a transfer on the first rising edge after rst deasserts.

Configuration
REQ-035 SHALL, with macro NORM_SHIFT_ZCOUNT_EN defined, add output zcount[15:0]: a saturating count of outputs transferred with zero=1, reset to 0 by rst or sclr.
REQ-036 SHALL, without NORM_SHIFT_ZCOUNT_EN, have no zcount port and no counter logic.

Structure
REQ-037 SHALL place the cLog2 constant function and the lo field-split helpers (found bit, index) in the shared package norm_pkg.
REQ-038 SHALL implement the shift as one sub-module, barrel_shl: combinational, log2 stages, parameterized by xWL.

Verification
REQ-039 SHALL cover: x=32'h0000_0001, lo={1,5'd0}, out_ready=1 -> two cycles later y=32'h8000_0000, shamt=31, zero=0.
REQ-040 SHALL cover: x=32'h0000_0000, lo={1'b0,5'd7} -> y=0, shamt=0, zero=1; with the macro defined, zcount increments from 0 to 1.
REQ-041 SHALL cover: 4 back-to-back inputs (x=1, 2, 4, 8 with matching lo), out_ready=0 for 5 cycles then 1:
- in_ready falls after 2 acceptances.
- Outputs are shamt=31, 30, 29, 28 in order, and y is held while stalled.
REQ-042 SHALL cover: both stages valid, rst pulsed between clk edges -> out_valid=0 immediately and in_ready=1; the next operand after release emerges alone two cycles later.
REQ-043 SHALL cover: ce=0 for 3 cycles with out_valid=1 and out_ready=1 -> no transfer, outputs unchanged; the transfer completes on the first edge after ce=1.
REQ-044 SHALL cover: sclr=1 with an input transfer on the same edge -> out_valid stays 0 for the next 3 cycles.
